// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared state encoding and widths for the frame sequencer.
package frame_seq_pkg;
    localparam int OBSTACLE_W = 16;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, GAP, FLUSH, WAIT_PROJ, RELEASE} fs_state_t;
endpackage

// File: rtl/frame_watchdog.sv
// frame_watchdog: loadable down-counter that flags expiry when it reaches zero.
module frame_watchdog #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] load_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q;
    assign expired_o = cnt_q == '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else if (clear_i) cnt_q <= load_i;
        else if (enable_i && !expired_o) cnt_q <= cnt_q - 1'b1;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame scheduler that snapshots player state, paces obstacle
// words from BRAM into the projector and runs the done_in/done_out handshake.
module frame_sequencer import frame_seq_pkg::*; #(
    parameter int MAX_OBSTACLES = 64,
    parameter int ADDR_W        = 6,
    parameter int READ_LATENCY  = 2,
    parameter int OBSTACLE_GAP  = 8,
    parameter int TIMEOUT       = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [6:0]            obstacle_count,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [OBSTACLE_W-1:0] mem_data,
    input  logic signed [15:0]    player_height_in,
    input  logic [1:0]            player_lane_in,
    input  logic                  ducking_in,
    output logic signed [15:0]    player_height,
    output logic [1:0]            player_lane,
    output logic                  ducking,
    output logic [OBSTACLE_W-1:0] obstacle,
    output logic                  obstacle_valid,
    output logic                  proj_done,
    input  logic                  proj_done_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  timeout
);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int CNT_MAX = READ_LATENCY > OBSTACLE_GAP ? READ_LATENCY : OBSTACLE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    fs_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W:0]       idx_q, idx_d;
    logic [6:0]            remaining_q, remaining_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [OBSTACLE_W-1:0] obstacle_q, obstacle_d;
    logic signed [15:0]    height_q, height_d;
    logic [1:0]            lane_q, lane_d;
    logic                  duck_q, duck_d;
    logic                  valid_q, valid_d, proj_done_q, proj_done_d;
    logic                  frame_done_q, frame_done_d, overrun_q, overrun_d;
    logic                  timeout_q, timeout_d, wd_clear, wd_expired;

    frame_watchdog #(.W(TMO_W)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear),
        .enable_i  (state_q == WAIT_PROJ),
        .load_i    (TMO_W'(TIMEOUT - 1)),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        idx_d        = idx_q;
        remaining_d  = remaining_q;
        mem_addr_d   = mem_addr_q;
        obstacle_d   = obstacle_q;
        height_d     = height_q;
        lane_d       = lane_q;
        duck_d       = duck_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;
        wd_clear     = 1'b0;
        overrun_d    = frame_start && state_q != IDLE;
        case (state_q)
            IDLE: if (frame_start) begin
                state_d     = FETCH;
                height_d    = player_height_in;
                lane_d      = player_lane_in;
                duck_d      = ducking_in;
                remaining_d = obstacle_count > 7'(MAX_OBSTACLES) ? 7'(MAX_OBSTACLES) : obstacle_count;
                idx_d       = '0;
                mem_addr_d  = '0;
            end
            FETCH: state_d = remaining_q == '0 ? FLUSH : WAIT_DATA;
            WAIT_DATA: if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
                state_d     = GAP;
                obstacle_d  = mem_data;
                valid_d     = 1'b1;
                idx_d       = idx_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            // The address is loaded on entry to FETCH so it is visible during FETCH itself.
            GAP: if (cnt_q == CNT_W'(OBSTACLE_GAP)) begin
                state_d    = FETCH;
                mem_addr_d = remaining_q != '0 ? idx_q[ADDR_W-1:0] : mem_addr_q;
            end else cnt_d = cnt_q + 1'b1;
            FLUSH: begin
                state_d  = WAIT_PROJ;
                wd_clear = 1'b1;
            end
            WAIT_PROJ: if (proj_done_out) begin
                state_d      = RELEASE;
                frame_done_d = 1'b1;
            end else if (wd_expired) begin
                state_d   = RELEASE;
                timeout_d = 1'b1;
            end
            RELEASE: state_d = proj_done_out ? RELEASE : IDLE;
            default: state_d = IDLE;
        endcase
        proj_done_d = state_d == WAIT_PROJ;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            remaining_q  <= '0;
            mem_addr_q   <= '0;
            obstacle_q   <= '0;
            height_q     <= '0;
            lane_q       <= '0;
            duck_q       <= 1'b0;
            valid_q      <= 1'b0;
            proj_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            remaining_q  <= remaining_d;
            mem_addr_q   <= mem_addr_d;
            obstacle_q   <= obstacle_d;
            height_q     <= height_d;
            lane_q       <= lane_d;
            duck_q       <= duck_d;
            valid_q      <= valid_d;
            proj_done_q  <= proj_done_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end

    assign mem_addr       = mem_addr_q;
    assign obstacle       = obstacle_q;
    assign obstacle_valid = valid_q;
    assign player_height  = height_q;
    assign player_lane    = lane_q;
    assign ducking        = duck_q;
    assign proj_done      = proj_done_q;
    assign frame_done     = frame_done_q;
    assign overrun        = overrun_q;
    assign timeout        = timeout_q;
    assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized frames checked every cycle against a schedule model.
module tb_frame_sequencer;
    localparam int RL = 2, GAP = 8, MAXO = 64, TMO = 50;
    localparam int P = RL + 2 + GAP, S0 = 2 + RL;

    logic clk = 0, rst = 1, frame_start = 0, ducking_in = 0, proj_done_out = 0;
    logic [6:0] obstacle_count = 0;
    logic [5:0] mem_addr;
    logic [15:0] mem_data, obstacle;
    logic signed [15:0] player_height_in = 0, player_height;
    logic [1:0] player_lane_in = 0, player_lane;
    logic ducking, obstacle_valid, proj_done, busy, frame_done, overrun, timeout;

    frame_sequencer #(.MAX_OBSTACLES(MAXO), .ADDR_W(6), .READ_LATENCY(RL),
                      .OBSTACLE_GAP(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .obstacle_count(obstacle_count),
        .mem_addr(mem_addr), .mem_data(mem_data), .player_height_in(player_height_in),
        .player_lane_in(player_lane_in), .ducking_in(ducking_in), .player_height(player_height),
        .player_lane(player_lane), .ducking(ducking), .obstacle(obstacle),
        .obstacle_valid(obstacle_valid), .proj_done(proj_done), .proj_done_out(proj_done_out),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout(timeout));

    always #5 clk = ~clk;

    int cyc = 0, n_checks = 0, n_fail = 0, fid = -1;
    bit started = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // current frame description and the output values held over from the previous one
    bit fv = 0;
    int fc = 0, fn = 0, fd = 0, fh = 1;
    logic [15:0] fbase = 0, fph = 0, h_obs = 0, h_ph = 0;
    logic [1:0] fpl = 0, h_pl = 0;
    logic fdk = 0, h_dk = 0;
    logic [5:0] h_addr = 0;
    bit ovr_at[int];

    logic [5:0] pipe [RL];
    always @(posedge clk) begin
        pipe[0] <= mem_addr;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data = fbase + 16'(pipe[RL-1]);

    typedef struct packed {
        logic [5:0] addr; logic [15:0] obs; logic ov; logic [15:0] ph; logic [1:0] pl;
        logic dk, pd, busy, fdn, to;
    } exp_t;

    function automatic int rise_r();
        return fn == 0 ? 3 : S0 + (fn - 1) * P + GAP + 3;
    endfunction
    function automatic int fall_r();
        return fd >= 0 ? rise_r() + fd + 1 : rise_r() + TMO;
    endfunction
    function automatic int end_r();
        return fd >= 0 ? rise_r() + fd + fh + 1 : rise_r() + TMO + 1;
    endfunction
    function automatic bit proj_resp(int r);
        return fv && fd >= 0 && r >= rise_r() + fd && r < rise_r() + fd + fh;
    endfunction

    function automatic exp_t model(int r);
        exp_t e;
        int k;
        e = '0;
        e.addr = h_addr; e.obs = h_obs; e.ph = h_ph; e.pl = h_pl; e.dk = h_dk;
        if (fv && r >= 1) begin
            e.ph = fph; e.pl = fpl; e.dk = fdk;
            e.addr = fn == 0 ? 6'd0 : 6'((r - 1) / P < fn - 1 ? (r - 1) / P : fn - 1);
            k = r >= S0 ? (r - S0) / P : -1;
            if (k > fn - 1) k = fn - 1;
            if (k >= 0) e.obs = fbase + 16'(k);
            e.ov   = r >= S0 && (r - S0) % P == 0 && (r - S0) / P < fn;
            e.pd   = r >= rise_r() && r < fall_r();
            e.fdn  = fd >= 0 && r == fall_r();
            e.to   = fd < 0 && r == fall_r();
            e.busy = r < end_r();
        end
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d frame=%0d got=%h expected=%h", nm, cyc, fid, act, exp);
        end
    endtask

    always @(negedge clk) if (started && !rst) begin : compare
        exp_t e;
        int r;
        r = cyc - fc;
        e = model(r);
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("obstacle", 32'(obstacle), 32'(e.obs));
        chk("obstacle_valid", 32'(obstacle_valid), 32'(e.ov));
        chk("player", {14'd0, player_height, player_lane}, {14'd0, e.ph, e.pl});
        chk("ducking", 32'(ducking), 32'(e.dk));
        chk("proj_done", 32'(proj_done), 32'(e.pd));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("frame_done", 32'(frame_done), 32'(e.fdn));
        chk("timeout", 32'(timeout), 32'(e.to));
        chk("overrun", 32'(overrun), 32'(ovr_at.exists(cyc)));
        if (fid == 0 && (r == 4 || r == 16 || r == 28))
            chk("lit_strobe", {15'd0, obstacle_valid, obstacle}, {15'd1, 16'hA000 + 16'((r - 4) / 12)});
        if (fid == 0 && (r == 38 || r == 39)) chk("lit_pd_rise", 32'(proj_done), 32'(r == 39));
        if (fid == 0 && r == 45) chk("lit_frame_done", {frame_done, proj_done}, 2'b10);
        if (fid == 1 && (r == 2 || r == 3)) chk("lit_pd_zero_cnt", 32'(proj_done), 32'(r == 3));
        if (fid == 2 && r == 760) chk("lit_last_strobe", {obstacle_valid, mem_addr, obstacle}, {1'b1, 6'd63, 16'h103F});
        if (fid == 2 && r == 772) chk("lit_no_65th", 32'(obstacle_valid), 32'd0);
        if (fid == 3 && (r == 7 || r == 46)) chk("lit_overrun", 32'(overrun), 32'd1);
        if (fid == 4 && (r == 64 || r == 65)) chk("lit_timeout", {timeout, proj_done}, r == 65 ? 2'b10 : 2'b01);
        if (fid == 6 && r == 1) chk("lit_restart", {busy, mem_addr}, 7'b1000000);
    end

    task automatic step();
        @(posedge clk);
        #1;
        frame_start      = 0;
        player_height_in = 16'($urandom);
        player_lane_in   = 2'($urandom);
        ducking_in       = 1'($urandom);
        obstacle_count   = 7'($urandom);
        proj_done_out    = proj_resp(cyc - fc);
    endtask

    task automatic start_frame(int n, logic [15:0] base, int d, int h);
        exp_t e;
        step();
        e = model(1000000);
        h_addr = e.addr; h_obs = e.obs; h_ph = e.ph; h_pl = e.pl; h_dk = e.dk;
        fv = 1; fc = cyc; fn = n > MAXO ? MAXO : n; fd = d; fh = h; fbase = base;
        fph = player_height_in; fpl = player_lane_in; fdk = ducking_in;
        obstacle_count = 7'(n);
        frame_start = 1;
        fid++;
        proj_done_out = proj_resp(0);
    endtask

    task automatic run_frame(int n, logic [15:0] base, int d, int h, int i1, int i2, int idle);
        start_frame(n, base, d, h);
        if (i1 == -2) i1 = $urandom_range(0, 1) == 1 ? int'($urandom_range(1, end_r() - 1)) : -1;
        for (int r = 1; r < end_r() + idle; r++) begin
            step();
            if (r == i1 || r == i2) begin
                frame_start = 1;
                ovr_at[cyc + 1] = 1;
            end
        end
    endtask

    initial begin
        repeat (3) step();
        rst = 0;
        started = 1;
        run_frame(3, 16'hA000, 5, 3, -1, -1, 0);
        run_frame(0, 16'h5500, 2, 1, -1, -1, 2);
        run_frame(100, 16'h1000, 1, 2, -1, -1, 1);
        run_frame(3, 16'h7700, 4, 4, 6, 45, 1);
        run_frame(1, 16'h3300, -1, 1, -1, -1, 2);
        start_frame(2, 16'hBEE0, 3, 1);
        step();
        step();
        #1 rst = 1;
        #1;
        chk("rst_outputs", {mem_addr, obstacle, obstacle_valid, player_height, player_lane, ducking,
                            proj_done, busy, frame_done, overrun, timeout}, '0);
        @(posedge clk);
        #1;
        rst = 0;
        fv = 0; h_addr = 0; h_obs = 0; h_ph = 0; h_pl = 0; h_dk = 0; proj_done_out = 0;
        step();
        run_frame(2, 16'hC000, 0, 1, -1, -1, 0);
        for (int f = 0; f < 10; f++)
            run_frame($urandom_range(0, 7) == 0 ? int'($urandom_range(65, 127)) : int'($urandom_range(0, 12)),
                      16'($urandom), $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 20)),
                      $urandom_range(1, 4), -2, -1, $urandom_range(0, 3));
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame scheduler in front of `full_projector`. On each `frame_start` it snapshots player state, streams the frame's obstacle words from the obstacle BRAM into the projector at a paced rate, and raises the projector's `done_in`. It then holds that handshake until the projector reports completion, releases it, and signals `frame_done`. A watchdog aborts a frame whose projection never completes; frame requests that arrive while busy are rejected and flagged.

## Interface
Parameters:
- `MAX_OBSTACLES`, 64: obstacle buffer depth; `obstacle_count` is clamped to this value.
- `ADDR_W`, 6: BRAM address width, equal to clog2(`MAX_OBSTACLES`).
- `READ_LATENCY`, 2: BRAM address-to-data latency in cycles; must be at least 1.
- `OBSTACLE_GAP`, 8: extra idle cycles inserted between consecutive obstacle issues; must be at least 0.
- `TIMEOUT`, 1048576: maximum cycles to wait for `proj_done_out`; must be at least 1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: single-cycle request to render one frame.
- `obstacle_count` in 7: number of valid obstacles this frame; sampled only with an accepted `frame_start`.
- `mem_addr` out `ADDR_W`: BRAM read address.
- `mem_data` in 16: BRAM read data, valid `READ_LATENCY` cycles after `mem_addr`.
- `player_height_in` in 16, signed: live player height.
- `player_lane_in` in 2: live player lane.
- `ducking_in` in 1: live ducking flag.
- `player_height` out 16, signed: per-frame latched copy of `player_height_in`, driven to the projector.
- `player_lane` out 2: per-frame latched copy of `player_lane_in`, driven to the projector.
- `ducking` out 1: per-frame latched copy of `ducking_in`, driven to the projector.
- `obstacle` out 16: obstacle word driven to the projector.
- `obstacle_valid` out 1: one-cycle strobe marking `obstacle` valid.
- `proj_done` out 1: drives the projector's `done_in`.
- `proj_done_out` in 1: the projector's `done_out`.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle strobe marking a completed frame.
- `overrun` out 1: one-cycle strobe marking a rejected `frame_start`.
- `timeout` out 1: one-cycle strobe marking a watchdog abort.

## Operation
States and transitions:
- **IDLE**: on `frame_start`, latch `player_*`, latch `min(obstacle_count, MAX_OBSTACLES)` into `remaining`, clear `idx`, go to FETCH.
- **FETCH**: drive `mem_addr = idx`. If `remaining == 0`, go to FLUSH; otherwise go to WAIT_DATA.
- **WAIT_DATA**: wait `READ_LATENCY` cycles, then register `obstacle <= mem_data` and pulse `obstacle_valid`. Increment `idx`, decrement `remaining`, go to GAP.
- **GAP**: count `OBSTACLE_GAP` cycles, then go to FETCH. When `OBSTACLE_GAP == 0`, go straight to FETCH.
- **FLUSH**: set `proj_done` to 1, clear the watchdog, go to WAIT_PROJ.
- **WAIT_PROJ**: hold `proj_done` high.
  - When `proj_done_out` is sampled high: clear `proj_done`, pulse `frame_done`, go to RELEASE.
  - When the watchdog reaches `TIMEOUT`: clear `proj_done`, pulse `timeout`, go to RELEASE, with no `frame_done`.
- **RELEASE**: wait for `proj_done_out` low, then go to IDLE.

Rules:
- `frame_start` seen in any state other than IDLE is ignored and produces an `overrun` pulse on the next cycle. It has no other effect.
- Player outputs change only on an accepted `frame_start`.
- `obstacle` holds its last value between strobes.
- `mem_addr` holds its last value outside FETCH/WAIT_DATA.
- `idx` never wraps, because the count is clamped.
- `obstacle_count` values above `MAX_OBSTACLES`, up to 127, are clamped silently.

## Timing
- Reset values: every output is 0, state is IDLE. This applies immediately on `rst`, including mid-frame. After reset release, IDLE accepts `frame_start` on the first clock.
- Cycle numbering: `frame_start` is sampled at edge 0.
  - `busy` and player outputs update at cycle 1.
  - `mem_addr = 0` is driven at cycle 1.
  - The first `obstacle_valid` occurs at cycle `2 + READ_LATENCY`.
- Obstacle pacing: consecutive `obstacle_valid` strobes are exactly `READ_LATENCY + 2 + OBSTACLE_GAP` cycles apart. This is 12 with default parameters.
- `proj_done` rises `OBSTACLE_GAP + 3` cycles after the last strobe. With `obstacle_count == 0`, it rises at cycle 3.
- When `proj_done_out` is sampled high at edge t, `proj_done` falls at t+1, and `frame_done` is high during cycle t+1.
- Watchdog: with no `proj_done_out`, `timeout` pulses and `proj_done` falls exactly `TIMEOUT` cycles after `proj_done` rises.
- `busy` falls on the cycle after RELEASE sees `proj_done_out == 0`.

## Structure
- Package `frame_seq_pkg`: the `fs_state_t` enum (IDLE, FETCH, WAIT_DATA, GAP, FLUSH, WAIT_PROJ, RELEASE) and `localparam OBSTACLE_W = 16`.
- Sub-module `frame_watchdog`: a loadable down-counter with `clear`, `enable`, and an `expired` output. It is instantiated once for the timeout.
- The latency and gap counters stay inline.

## Test plan
- Defaults, `obstacle_count = 3`, BRAM model returning `0xA000 + addr`: strobes at cycles 4, 16, 28 carry 0xA000, 0xA001, 0xA002. `proj_done` rises at cycle 39. Projector model asserts `proj_done_out` 5 cycles later, producing exactly one `frame_done`.
- `obstacle_count = 0`: no `obstacle_valid`, `proj_done` rises at cycle 3, `frame_done` follows the projector handshake.
- `obstacle_count = 100`: exactly 64 strobes, addresses 0..63, no wrap.
- `frame_start` pulsed during GAP and again during RELEASE: two `overrun` pulses, and the in-flight obstacle sequence and player latches are unchanged.
- `TIMEOUT = 50`, projector never responds: `timeout` pulses at `proj_done` rise + 50, no `frame_done`, `busy` drops once `proj_done_out` is 0.
- `rst` asserted mid-WAIT_DATA: all outputs are 0 immediately. After release, a fresh `frame_start` restarts from address 0.
